// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 codes,
// FSM states and the width/step legality check.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic bit nk_legal(input int n, input int k);
    return (k == 1 || k == 2 || k == 4) && (n > k) && (n % k == 0);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract
// the divisor when it fits, and report the resulting quotient bit.
module muldiv_div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0] shifted;
  logic [N:0] diff;

  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // The running remainder stays below the divisor, so N bits always suffice.
  assign rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, K bits
// per cycle shift-add multiply or restoring divide, sign fix-up at the end.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int ITER = N / K;
  localparam int CW = $clog2(ITER) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (!nk_legal(N, K)) begin : g_bad_nk
    $error("muldiv_unit: N must be a multiple of K and K must be 1, 2 or 4");
  end

  state_t state, state_next;

  logic [2:0]     f3_reg;
  logic [N-1:0]   opnd_reg;
  logic [2*N-1:0] acc_reg;
  logic           sign_a_reg, sign_b_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   result_reg;

  logic           a_signed, b_signed, neg_a, neg_b, is_div;
  logic           div_zero, div_ovf, special, launch;
  logic [N-1:0]   a_mag, b_mag, special_val;

  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    neg_a    = a_signed & op_a[N-1];
    neg_b    = b_signed & op_b[N-1];
    a_mag    = neg_a ? -op_a : op_a;
    b_mag    = neg_b ? -op_b : op_b;
    is_div   = funct3[2];
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(N-1){1'b0}}}) && (op_b == '1);
    special  = div_zero || div_ovf;
    // funct3[1] selects the remainder flavour of the divide ops
    if (div_zero) special_val = funct3[1] ? op_a : '1;
    else          special_val = funct3[1] ? '0 : op_a;
    launch   = (state == S_IDLE) && start && !flush;
  end

  // Multiply: K chained shift-add steps over {high partial, multiplier}.
  logic [2*N-1:0] mul_next;
  logic [N:0]     mul_sum;

  always_comb begin
    mul_next = acc_reg;
    mul_sum  = '0;
    for (int j = 0; j < K; j++) begin
      mul_sum  = {1'b0, mul_next[2*N-1:N]} + (mul_next[0] ? {1'b0, opnd_reg} : '0);
      mul_next = {mul_sum, mul_next[N-1:1]};
    end
  end

  // Divide: acc_reg holds {remainder, dividend shifting out / quotient shifting in}.
  logic [N-1:0]   rem_chain [0:K];
  logic [K-1:0]   q_bits;
  logic [2*N-1:0] div_next;

  assign rem_chain[0] = acc_reg[2*N-1:N];

  for (genvar gi = 0; gi < K; gi++) begin : g_div
    muldiv_div_step #(.N(N)) u_step (
      .rem_in  (rem_chain[gi]),
      .bit_in  (acc_reg[N-1-gi]),
      .divisor (opnd_reg),
      .rem_out (rem_chain[gi+1]),
      .q_bit   (q_bits[K-1-gi])
    );
  end

  assign div_next = {rem_chain[K], acc_reg[N-K-1:0], q_bits};

  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[N-1:0] : acc_reg[N-1:0];
    rem_fix  = sign_a_reg ? -acc_reg[2*N-1:N] : acc_reg[2*N-1:N];
    if (f3_reg[2])             fix_val = f3_reg[1] ? rem_fix : quo_fix;
    else if (f3_reg == F3_MUL) fix_val = prod_fix[N-1:0];
    else                       fix_val = prod_fix[2*N-1:N];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (launch) state_next = special ? S_DONE : (is_div ? S_DIV : S_MUL);
      S_MUL, S_DIV: begin
        if (flush)                state_next = S_IDLE;
        else if (cnt_reg == LAST) state_next = S_FIX;
      end
      S_FIX:   state_next = flush ? S_IDLE : S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f3_reg     <= '0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
    end else if (launch) begin
      f3_reg     <= funct3;
      sign_a_reg <= neg_a;
      sign_b_reg <= neg_b;
      cnt_reg    <= '0;
      opnd_reg   <= is_div ? b_mag : a_mag;
      acc_reg    <= {{N{1'b0}}, (is_div ? a_mag : b_mag)};
      if (special) result_reg <= special_val;
    end else if (state == S_MUL || state == S_DIV) begin
      acc_reg <= (state == S_MUL) ? mul_next : div_next;
      cnt_reg <= cnt_reg + 1'b1;
    end else if (state == S_FIX && !flush) begin
      result_reg <= fix_val;
    end
  end

  assign result = result_reg;

endmodule
